// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the FFT stage controllers.
//   - state_t       : frame FSM encoding (S_IDLE, S_RUN)
//   - LOG2N_*_DEF   : default frame-size bounds
//   - awidth()      : twiddle ROM address width for a given LOG2N_MAX;
//                     depends on TWID_QUARTER_ROM_EN (quarter-wave ROM)
//   - clamp_log2n() : clamp a requested frame log2 into [lo, hi]
package fft_pkg;

    localparam int LOG2N_MAX_DEF = 10;
    localparam int LOG2N_MIN_DEF = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Half-wave ROM holds N_MAX/2 words, quarter-wave ROM N_MAX/4.
    function automatic int awidth(input int log2n_max);
`ifdef TWID_QUARTER_ROM_EN
        return log2n_max - 2;
`else
        return log2n_max - 1;
`endif
    endfunction

    function automatic logic [3:0] clamp_log2n(input logic [3:0] v, input int lo, input int hi);
        logic [3:0] r;
        r = v;
        if (v < 4'(lo))
            r = 4'(lo);
        else if (v > 4'(hi))
            r = 4'(hi);
        return r;
    endfunction

endpackage

// File: rtl/twiddle_sched_if.sv
// twiddle_sched_if -- sample/twiddle bus of twiddle_sched.
//   i_valid, i_data, i_log2n, i_flush : upstream sample stream into the controller
//   o_valid, o_data                   : sample forwarded one cycle later
//   o_addr, o_sign_inv, o_rot         : twiddle ROM address and correction flags
//   o_trivial                         : exponent is 0 (multiplier bypass)
//   o_frame_start, o_frame_end        : output sample is index 0 / N-1
//   o_busy                            : a frame is partially received
// Modports: master drives samples (butterfly side), slave is the controller.
interface twiddle_sched_if
    import fft_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int LOG2N_MAX = LOG2N_MAX_DEF
) ();
    localparam int AWIDTH = awidth(LOG2N_MAX);

    logic              i_valid;
    logic [DWIDTH-1:0] i_data;
    logic [3:0]        i_log2n;
    logic              i_flush;

    logic              o_valid;
    logic [DWIDTH-1:0] o_data;
    logic [AWIDTH-1:0] o_addr;
    logic              o_sign_inv;
    logic              o_rot;
    logic              o_trivial;
    logic              o_frame_start;
    logic              o_frame_end;
    logic              o_busy;

    modport master (
        output i_valid, i_data, i_log2n, i_flush,
        input  o_valid, o_data, o_addr, o_sign_inv, o_rot, o_trivial,
               o_frame_start, o_frame_end, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_log2n, i_flush,
        output o_valid, o_data, o_addr, o_sign_inv, o_rot, o_trivial,
               o_frame_start, o_frame_end, o_busy
    );
endinterface

// File: rtl/twid_exp_map.sv
// twid_exp_map -- combinational twiddle mapping for an R2^2SDF stage.
// Given sample index n within a frame of N = 2^log2n, derives the exponent
//   quarter 0: 0, quarter 1: 2k, quarter 2: k, quarter 3: 3k  (k = n mod N/4)
// scales it into the N_MAX ROM domain and splits it into ROM address and
// symmetry flags.
// Ports:
//   n        in  sample index (< 2^log2n)
//   log2n    in  frame log2, 2 <= log2n <= LOG2N_MAX
//   addr     out ROM address
//   sign_inv out negate the ROM word
//   rot      out multiply the ROM word by -j (0 unless TWID_QUARTER_ROM_EN)
//   trivial  out exponent is 0
// Macro TWID_QUARTER_ROM_EN selects the quarter-wave split.
module twid_exp_map
    import fft_pkg::*;
#(
    parameter int LOG2N_MAX = LOG2N_MAX_DEF,
    parameter int AWIDTH    = awidth(LOG2N_MAX)
) (
    input  logic [LOG2N_MAX-1:0] n,
    input  logic [3:0]           log2n,
    output logic [AWIDTH-1:0]    addr,
    output logic                 sign_inv,
    output logic                 rot,
    output logic                 trivial
);
    localparam logic [3:0] LMAX = 4'(LOG2N_MAX);

    logic [LOG2N_MAX-1:0] kmask;
    logic [LOG2N_MAX-1:0] k;
    logic [1:0]           q;
    logic [LOG2N_MAX-1:0] e;
    logic [LOG2N_MAX-1:0] e_scl;

    always_comb begin
        // N/4 - 1 as a mask, and the quarter index n / (N/4)
        kmask = {LOG2N_MAX{1'b1}} >> (LMAX - log2n + 4'd2);
        q     = 2'(n >> (log2n - 4'd2));
        k     = n & kmask;
        e     = '0;
        case (q)
            2'd1:    e = k << 1;
            2'd2:    e = k;
            2'd3:    e = (k << 1) + k;
            default: e = '0;
        endcase
        // e < 3N/4 so the shifted value never overflows LOG2N_MAX bits
        e_scl = e << (LMAX - log2n);
    end

`ifdef TWID_QUARTER_ROM_EN
    assign addr     = e_scl[LOG2N_MAX-3:0];
    assign rot      = e_scl[LOG2N_MAX-2];
`else
    assign addr     = e_scl[LOG2N_MAX-2:0];
    assign rot      = 1'b0;
`endif
    assign sign_inv = e_scl[LOG2N_MAX-1];
    assign trivial  = (e == '0);

endmodule

// File: rtl/twiddle_sched.sv
// twiddle_sched -- twiddle schedule controller for one R2^2SDF multiplier stage.
// Counts samples within a frame (holding across valid gaps), latches the frame
// size on the first sample, and forwards each sample one cycle later together
// with its twiddle ROM address and correction flags.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   bus    slave side of twiddle_sched_if (samples in, sample + twiddle out)
// Macro TWID_QUARTER_ROM_EN selects the quarter-wave ROM mapping (o_rot live).
module twiddle_sched
    import fft_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int LOG2N_MAX = LOG2N_MAX_DEF,
    parameter int LOG2N_MIN = LOG2N_MIN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    twiddle_sched_if.slave bus
);
    localparam int AWIDTH = awidth(LOG2N_MAX);
    localparam int NW     = LOG2N_MAX;

    state_t          state, state_nx;
    logic [NW-1:0]   cnt, cnt_nx;
    logic [3:0]      l_q, l_nx;
    logic [3:0]      cur_l;
    logic [NW-1:0]   last_n;
    logic            is_last;
    logic            accept;

    logic [AWIDTH-1:0] map_addr;
    logic              map_sign, map_rot, map_triv;

    logic              vld_q;
    logic [DWIDTH-1:0] data_q;
    logic [AWIDTH-1:0] addr_q;
    logic              sign_q, rot_q, triv_q, fstart_q, fend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            l_q   <= 4'(LOG2N_MAX);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            l_q   <= l_nx;
        end
    end

    always_comb begin
        accept   = bus.i_valid & ~bus.i_flush;
        // The first sample of a frame uses the request directly; the rest use
        // the latched size so mid-frame changes of i_log2n are ignored.
        cur_l    = (state == S_IDLE) ? clamp_log2n(bus.i_log2n, LOG2N_MIN, LOG2N_MAX) : l_q;
        last_n   = {NW{1'b1}} >> (4'(NW) - cur_l);
        is_last  = (cnt == last_n);
        state_nx = state;
        cnt_nx   = cnt;
        l_nx     = l_q;
        if (bus.i_flush) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (bus.i_valid) begin
            if (state == S_IDLE)
                l_nx = cur_l;
            // cnt is 0 in S_IDLE and N >= 4, so the first sample never wraps
            if (is_last) begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end else begin
                cnt_nx   = cnt + 1'b1;
                state_nx = S_RUN;
            end
        end
    end

    twid_exp_map #(
        .LOG2N_MAX (LOG2N_MAX),
        .AWIDTH    (AWIDTH)
    ) u_map (
        .n        (cnt),
        .log2n    (cur_l),
        .addr     (map_addr),
        .sign_inv (map_sign),
        .rot      (map_rot),
        .trivial  (map_triv)
    );

    // Control fields are zero whenever the output sample is not valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            sign_q   <= 1'b0;
            rot_q    <= 1'b0;
            triv_q   <= 1'b0;
            fstart_q <= 1'b0;
            fend_q   <= 1'b0;
        end else begin
            vld_q    <= accept;
            if (accept)
                data_q <= bus.i_data;
            addr_q   <= accept ? map_addr : '0;
            sign_q   <= accept & map_sign;
            rot_q    <= accept & map_rot;
            triv_q   <= accept & map_triv;
            fstart_q <= accept & (cnt == '0);
            fend_q   <= accept & is_last;
        end
    end

    assign bus.o_valid       = vld_q;
    assign bus.o_data        = data_q;
    assign bus.o_addr        = addr_q;
    assign bus.o_sign_inv    = sign_q;
    assign bus.o_rot         = rot_q;
    assign bus.o_trivial     = triv_q;
    assign bus.o_frame_start = fstart_q;
    assign bus.o_frame_end   = fend_q;
    assign bus.o_busy        = (state == S_RUN);

endmodule

// File: tb/tb_twiddle_sched.sv
// tb_twiddle_sched -- directed bench for twiddle_sched with LOG2N_MAX=4.
// dut   : LOG2N_MIN=3 (allows the N=8 frame cases)
// dut_b : LOG2N_MIN=4, same stimulus, used for the low-side clamp case
// Expected twiddle fields come from hand-computed tables for N=16 and N=8.
module tb_twiddle_sched;
    import fft_pkg::*;

    localparam int LMAX = 4;
    localparam int AW   = awidth(LMAX);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    twiddle_sched_if #(.DWIDTH(32), .LOG2N_MAX(LMAX)) bus_a ();
    twiddle_sched_if #(.DWIDTH(32), .LOG2N_MAX(LMAX)) bus_b ();

    assign bus_b.i_valid = bus_a.i_valid;
    assign bus_b.i_data  = bus_a.i_data;
    assign bus_b.i_log2n = bus_a.i_log2n;
    assign bus_b.i_flush = bus_a.i_flush;

    twiddle_sched #(.DWIDTH(32), .LOG2N_MAX(LMAX), .LOG2N_MIN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    twiddle_sched #(.DWIDTH(32), .LOG2N_MAX(LMAX), .LOG2N_MIN(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

`ifdef TWID_QUARTER_ROM_EN
    int exp_addr16 [16] = '{0,0,0,0, 0,2,0,2, 0,1,2,3, 0,3,2,1};
    int exp_rot16  [16] = '{0,0,0,0, 0,0,1,1, 0,0,0,0, 0,0,1,0};
    int exp_addr8  [8]  = '{0,0,0,0, 0,2,0,2};
    int exp_rot8   [8]  = '{0,0,0,1, 0,0,0,1};
`else
    int exp_addr16 [16] = '{0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,1};
    int exp_rot16  [16] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    int exp_addr8  [8]  = '{0,0,0,4, 0,2,0,6};
    int exp_rot8   [8]  = '{0,0,0,0, 0,0,0,0};
`endif
    int exp_triv16 [16] = '{1,1,1,1, 1,0,0,0, 1,0,0,0, 1,0,0,0};
    int exp_triv8  [8]  = '{1,1,1,0, 1,0,1,0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] l, input logic f);
        bus_a.i_valid = v;
        bus_a.i_data  = d;
        bus_a.i_log2n = l;
        bus_a.i_flush = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 4'd4, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 4'd4, 1'b0);
        tick();
        tick();
        checks++;
        if (bus_a.o_valid !== 1'b0 || bus_a.o_data !== 32'h0) begin
            errors++;
            $display("FAIL reset valid/data got %b/%h want 0/0", bus_a.o_valid, bus_a.o_data);
        end
        checks++;
        if (bus_a.o_addr !== AW'(0) || bus_a.o_sign_inv !== 1'b0 || bus_a.o_rot !== 1'b0 ||
            bus_a.o_trivial !== 1'b0 || bus_a.o_frame_start !== 1'b0 || bus_a.o_frame_end !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl got addr=%0d s=%b r=%b t=%b fs=%b fe=%b want all 0", bus_a.o_addr,
                     bus_a.o_sign_inv, bus_a.o_rot, bus_a.o_trivial, bus_a.o_frame_start, bus_a.o_frame_end);
        end
        checks++;
        if (bus_a.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy got %b want 0", bus_a.o_busy);
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'd4, 1'b0);
        tick();
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 32'hA000 + 32'(n), 4'd4, 1'b0);
            tick();
            checks++;
            if (bus_a.o_valid !== 1'b1 || bus_a.o_data !== 32'hA000 + 32'(n)) begin
                errors++;
                $display("FAIL full_frame valid/data n=%0d got %b/%h want 1/%h", n, bus_a.o_valid,
                         bus_a.o_data, 32'hA000 + 32'(n));
            end
            checks++;
            if (bus_a.o_addr !== AW'(exp_addr16[n]) || bus_a.o_rot !== 1'(exp_rot16[n]) ||
                bus_a.o_sign_inv !== (n == 15)) begin
                errors++;
                $display("FAIL full_frame twiddle n=%0d got addr=%0d rot=%b sign=%b want %0d/%0d/%0d", n,
                         bus_a.o_addr, bus_a.o_rot, bus_a.o_sign_inv, exp_addr16[n], exp_rot16[n], n == 15);
            end
            checks++;
            if (bus_a.o_trivial !== 1'(exp_triv16[n])) begin
                errors++;
                $display("FAIL full_frame trivial n=%0d got %b want %0d", n, bus_a.o_trivial, exp_triv16[n]);
            end
            checks++;
            if (bus_a.o_frame_start !== (n == 0) || bus_a.o_frame_end !== (n == 15)) begin
                errors++;
                $display("FAIL full_frame start/end n=%0d got %b/%b want %b/%b", n, bus_a.o_frame_start,
                         bus_a.o_frame_end, n == 0, n == 15);
            end
            checks++;
            if (bus_a.o_busy !== (n != 15)) begin
                errors++;
                $display("FAIL full_frame busy n=%0d got %b want %b", n, bus_a.o_busy, n != 15);
            end
        end
        drive(1'b0, 32'h0, 4'd4, 1'b0);
        tick();
        checks++;
        if (bus_a.o_valid !== 1'b0 || bus_a.o_addr !== AW'(0) || bus_a.o_sign_inv !== 1'b0) begin
            errors++;
            $display("FAIL full_frame idle got valid=%b addr=%0d sign=%b want 0/0/0", bus_a.o_valid,
                     bus_a.o_addr, bus_a.o_sign_inv);
        end
    endtask

    task automatic test_small_frame();
        do_reset();
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, 32'hB000 + 32'(n), 4'd3, 1'b0);
            tick();
            checks++;
            if (bus_a.o_addr !== AW'(exp_addr8[n]) || bus_a.o_rot !== 1'(exp_rot8[n]) ||
                bus_a.o_sign_inv !== 1'b0 || bus_a.o_trivial !== 1'(exp_triv8[n])) begin
                errors++;
                $display("FAIL small_frame twiddle n=%0d got addr=%0d rot=%b sign=%b triv=%b want %0d/%0d/0/%0d",
                         n, bus_a.o_addr, bus_a.o_rot, bus_a.o_sign_inv, bus_a.o_trivial,
                         exp_addr8[n], exp_rot8[n], exp_triv8[n]);
            end
            checks++;
            if (bus_a.o_frame_end !== (n == 7) || bus_a.o_busy !== (n != 7)) begin
                errors++;
                $display("FAIL small_frame end/busy n=%0d got %b/%b want %b/%b", n, bus_a.o_frame_end,
                         bus_a.o_busy, n == 7, n != 7);
            end
        end
        // next cycle: new frame with no bubble
        drive(1'b1, 32'hB100, 4'd3, 1'b0);
        tick();
        checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_frame_start !== 1'b1 || bus_a.o_data !== 32'hB100 ||
            bus_a.o_trivial !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back got valid=%b start=%b data=%h triv=%b want 1/1/b100/1",
                     bus_a.o_valid, bus_a.o_frame_start, bus_a.o_data, bus_a.o_trivial);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 16; n++) begin
                int g;
                g = int'($urandom_range(1, 3));
                for (int i = 0; i < g; i++) begin
                    drive(1'b0, 32'h5555_5555, 4'd3, 1'b0);
                    tick();
                    checks++;
                    if (bus_a.o_valid !== 1'b0 || bus_a.o_busy !== (n != 0)) begin
                        errors++;
                        $display("FAIL gaps idle f=%0d n=%0d got valid=%b busy=%b want 0/%b", f, n,
                                 bus_a.o_valid, bus_a.o_busy, n != 0);
                    end
                end
                drive(1'b1, 32'hC000 + 32'(n), 4'd4, 1'b0);
                tick();
                checks++;
                if (bus_a.o_valid !== 1'b1 || bus_a.o_data !== 32'hC000 + 32'(n) ||
                    bus_a.o_addr !== AW'(exp_addr16[n]) || bus_a.o_rot !== 1'(exp_rot16[n]) ||
                    bus_a.o_sign_inv !== (n == 15) || bus_a.o_trivial !== 1'(exp_triv16[n]) ||
                    bus_a.o_frame_start !== (n == 0) || bus_a.o_frame_end !== (n == 15)) begin
                    errors++;
                    $display("FAIL gaps sample f=%0d n=%0d got v=%b d=%h a=%0d r=%b s=%b t=%b fs=%b fe=%b want a=%0d r=%0d t=%0d",
                             f, n, bus_a.o_valid, bus_a.o_data, bus_a.o_addr, bus_a.o_rot, bus_a.o_sign_inv,
                             bus_a.o_trivial, bus_a.o_frame_start, bus_a.o_frame_end,
                             exp_addr16[n], exp_rot16[n], exp_triv16[n]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int n = 0; n < 9; n++) begin
            drive(1'b1, 32'hD000 + 32'(n), 4'd4, 1'b0);
            tick();
        end
        drive(1'b1, 32'hD009, 4'd4, 1'b1);
        tick();
        checks++;
        if (bus_a.o_valid !== 1'b0 || bus_a.o_addr !== AW'(0) || bus_a.o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL flush drop got valid=%b addr=%0d start=%b want 0/0/0", bus_a.o_valid,
                     bus_a.o_addr, bus_a.o_frame_start);
        end
        checks++;
        if (bus_a.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush busy got %b want 0", bus_a.o_busy);
        end
        drive(1'b1, 32'hD100, 4'd4, 1'b0);
        tick();
        checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_frame_start !== 1'b1 || bus_a.o_addr !== AW'(0) ||
            bus_a.o_data !== 32'hD100 || bus_a.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush restart got valid=%b start=%b addr=%0d data=%h busy=%b want 1/1/0/d100/1",
                     bus_a.o_valid, bus_a.o_frame_start, bus_a.o_addr, bus_a.o_data, bus_a.o_busy);
        end
        // n=5 of the restarted frame must map as index 5, not 14
        for (int n = 1; n < 6; n++) begin
            drive(1'b1, 32'hD100 + 32'(n), 4'd4, 1'b0);
            tick();
        end
        checks++;
        if (bus_a.o_addr !== AW'(exp_addr16[5]) || bus_a.o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL flush n5 got addr=%0d start=%b want %0d/0", bus_a.o_addr,
                     bus_a.o_frame_start, exp_addr16[5]);
        end
    endtask

    task automatic test_log2n_change();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 32'hE000 + 32'(n), (n < 6) ? 4'd4 : 4'd3, 1'b0);
            tick();
            checks++;
            if (bus_a.o_frame_end !== (n == 15) || bus_a.o_addr !== AW'(exp_addr16[n]) ||
                bus_a.o_sign_inv !== (n == 15)) begin
                errors++;
                $display("FAIL log2n_change n=%0d got end=%b addr=%0d sign=%b want %b/%0d/%b", n,
                         bus_a.o_frame_end, bus_a.o_addr, bus_a.o_sign_inv, n == 15, exp_addr16[n], n == 15);
            end
        end
        // request above LOG2N_MAX clamps to N=16
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 32'hE100 + 32'(n), 4'd15, 1'b0);
            tick();
            checks++;
            if (bus_a.o_frame_end !== (n == 15) || bus_a.o_frame_start !== (n == 0) ||
                bus_a.o_addr !== AW'(exp_addr16[n])) begin
                errors++;
                $display("FAIL clamp_high n=%0d got end=%b start=%b addr=%0d want %b/%b/%0d", n,
                         bus_a.o_frame_end, bus_a.o_frame_start, bus_a.o_addr, n == 15, n == 0, exp_addr16[n]);
            end
        end
    endtask

    task automatic test_clamp_low();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 32'hF000 + 32'(n), 4'd2, 1'b0);
            tick();
            // LOG2N_MIN=4: 2 -> 4, one N=16 frame
            checks++;
            if (bus_b.o_frame_end !== (n == 15) || bus_b.o_addr !== AW'(exp_addr16[n])) begin
                errors++;
                $display("FAIL clamp_low_min4 n=%0d got end=%b addr=%0d want %b/%0d", n,
                         bus_b.o_frame_end, bus_b.o_addr, n == 15, exp_addr16[n]);
            end
            // LOG2N_MIN=3: 2 -> 3, two N=8 frames
            checks++;
            if (bus_a.o_frame_end !== (n % 8 == 7) || bus_a.o_frame_start !== (n % 8 == 0) ||
                bus_a.o_addr !== AW'(exp_addr8[n % 8])) begin
                errors++;
                $display("FAIL clamp_low_min3 n=%0d got end=%b start=%b addr=%0d want %b/%b/%0d", n,
                         bus_a.o_frame_end, bus_a.o_frame_start, bus_a.o_addr, n % 8 == 7, n % 8 == 0,
                         exp_addr8[n % 8]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 4'd4, 1'b0);
        test_reset();
        test_full_frame();
        test_small_frame();
        test_gaps();
        test_flush();
        test_log2n_change();
        test_clamp_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
